csi2_rx_packet_controller: RTL and testbench

//  Sequences a single-lane HS-only D-PHY receiver, which cannot detect LP states and needs a

---
 rtl/csi2_pkg.sv | 33 +++
 rtl/csi2_crc16.sv | 39 +++
 rtl/csi2_rx_packet_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_csi2_rx_packet_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
`default_nettype none
// ==========================================================================
// csi2_pkg : shared state type, data-type constants and CRC-16 step
// Rev 1.0
// ==========================================================================
package csi2_pkg;

  typedef enum logic [2:0] {
    RESET   = 3'd0,
    IDLE    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4
  } rx_state_t;

  localparam logic [5:0]  DT_LONG_MIN    = 6'h10;
  localparam logic [5:0]  DT_FRAME_START = 6'h00;
  localparam logic [5:0]  DT_FRAME_END   = 6'h01;
  localparam logic [15:0] CRC_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL  = 16'h8408;

  // One byte of the reflected CRC-16/CCITT, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi2_crc16.sv
`default_nettype none
// ==========================================================================
// csi2_crc16 : byte-serial CRC-16 accumulator over the packet payload
// Rev 1.0
// ==========================================================================
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clock_p,
  input  logic        reset_n,
  input  logic        init,
  input  logic [7:0]  data_byte,
  input  logic        valid,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (valid) begin
      crc_d = crc16_byte(crc_q, data_byte);
    end
  end

  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/csi2_rx_packet_controller.sv
`default_nettype none
// ==========================================================================
// csi2_rx_packet_controller : CSI-2 packet parser and sequencer for an
// HS-only D-PHY receiver. Optional payload CRC check: CSI2_CRC_CHECK_EN.
// Rev 1.0
// ==========================================================================
module csi2_rx_packet_controller
  import csi2_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clock_p,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic        phy_reset,
  output logic        header_valid,
  output logic [7:0]  data_id,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        is_long,
  output logic [7:0]  payload,
  output logic        payload_valid,
  output logic        packet_end,
  output logic        aborted,
  output logic        crc_error
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  rx_state_t     state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [7:0]    di_q, di_d;
  logic [15:0]   wc_q, wc_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic          crc_idx_q, crc_idx_d;
  logic [7:0]    crc_lo_q, crc_lo_d;

  logic          phy_reset_q, phy_reset_d;
  logic          header_valid_q, header_valid_d;
  logic [7:0]    data_id_q, data_id_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [7:0]    ecc_q, ecc_d;
  logic          is_long_q, is_long_d;
  logic [7:0]    payload_q, payload_d;
  logic          payload_valid_q, payload_valid_d;
  logic          packet_end_q, packet_end_d;
  logic          aborted_q, aborted_d;
  logic          crc_error_q, crc_error_d;

  logic          crc_init, crc_mismatch, in_packet, timeout_hit, long_pkt;

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_calc;

  csi2_crc16 u_crc16 (
    .clock_p   (clock_p),
    .reset_n   (reset_n),
    .init      (crc_init),
    .data_byte (rx_data),
    .valid     (state_q == PAYLOAD && rx_enable),
    .crc       (crc_calc)
  );

  // Only meaningful while the second (msb) CRC byte is on rx_data.
  assign crc_mismatch = ({rx_data, crc_lo_q} != crc_calc);
`else
  logic crc_unused;
  assign crc_unused   = ^{crc_init, crc_lo_q};
  assign crc_mismatch = 1'b0;
`endif

  assign in_packet   = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == CRC);
  assign timeout_hit = in_packet && !rx_enable && (idle_cnt_q == IDLE_MAX);
  assign long_pkt    = (di_q[5:0] >= DT_LONG_MIN);

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    idle_cnt_d      = '0;
    hdr_idx_d       = hdr_idx_q;
    di_d            = di_q;
    wc_d            = wc_q;
    byte_cnt_d      = byte_cnt_q;
    crc_idx_d       = crc_idx_q;
    crc_lo_d        = crc_lo_q;
    header_valid_d  = 1'b0;
    data_id_d       = data_id_q;
    word_count_d    = word_count_q;
    ecc_d           = ecc_q;
    is_long_d       = is_long_q;
    payload_d       = payload_q;
    payload_valid_d = 1'b0;
    packet_end_d    = 1'b0;
    aborted_d       = 1'b0;
    crc_error_d     = 1'b0;
    crc_init        = 1'b0;

    if (in_packet && !rx_enable && !timeout_hit) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    case (state_q)
      RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (rx_enable) begin
          di_d      = rx_data;
          hdr_idx_d = 2'd1;
          crc_init  = 1'b1;
          state_d   = HEADER;
        end
      end
      HEADER: begin
        if (rx_enable) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd1:    wc_d[7:0]  = rx_data;
            2'd2:    wc_d[15:8] = rx_data;
            default: begin
              header_valid_d = 1'b1;
              data_id_d      = di_q;
              word_count_d   = wc_q;
              ecc_d          = rx_data;
              is_long_d      = long_pkt;
              if (!long_pkt) begin
                packet_end_d = 1'b1;
                state_d      = RESET;
              end else if (wc_q == 16'd0) begin
                crc_idx_d = 1'b0;
                state_d   = CRC;
              end else begin
                byte_cnt_d = wc_q;
                state_d    = PAYLOAD;
              end
            end
          endcase
        end
      end
      PAYLOAD: begin
        if (rx_enable) begin
          payload_valid_d = 1'b1;
          payload_d       = rx_data;
          if (byte_cnt_q != 16'd0) begin
            byte_cnt_d = byte_cnt_q - 16'd1;
          end
          if (byte_cnt_q <= 16'd1) begin
            crc_idx_d = 1'b0;
            state_d   = CRC;
          end
        end
      end
      CRC: begin
        if (rx_enable) begin
          if (!crc_idx_q) begin
            crc_lo_d  = rx_data;
            crc_idx_d = 1'b1;
          end else begin
            packet_end_d = 1'b1;
            crc_error_d  = crc_mismatch;
            state_d      = RESET;
          end
        end
      end
      default: state_d = RESET;
    endcase

    if (timeout_hit) begin
      aborted_d = 1'b1;
      state_d   = RESET;
    end

    // Reloading on every entry keeps phy_reset high for exactly RESET_CYCLES clocks.
    if (state_d == RESET && state_q != RESET) begin
      rst_cnt_d = RST_LOAD;
    end
    phy_reset_d = (state_d == RESET);
  end

  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RESET;
      rst_cnt_q       <= RST_LOAD;
      idle_cnt_q      <= '0;
      hdr_idx_q       <= 2'd0;
      di_q            <= 8'h00;
      wc_q            <= 16'h0000;
      byte_cnt_q      <= 16'h0000;
      crc_idx_q       <= 1'b0;
      crc_lo_q        <= 8'h00;
      phy_reset_q     <= 1'b1;
      header_valid_q  <= 1'b0;
      data_id_q       <= 8'h00;
      word_count_q    <= 16'h0000;
      ecc_q           <= 8'h00;
      is_long_q       <= 1'b0;
      payload_q       <= 8'h00;
      payload_valid_q <= 1'b0;
      packet_end_q    <= 1'b0;
      aborted_q       <= 1'b0;
      crc_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      hdr_idx_q       <= hdr_idx_d;
      di_q            <= di_d;
      wc_q            <= wc_d;
      byte_cnt_q      <= byte_cnt_d;
      crc_idx_q       <= crc_idx_d;
      crc_lo_q        <= crc_lo_d;
      phy_reset_q     <= phy_reset_d;
      header_valid_q  <= header_valid_d;
      data_id_q       <= data_id_d;
      word_count_q    <= word_count_d;
      ecc_q           <= ecc_d;
      is_long_q       <= is_long_d;
      payload_q       <= payload_d;
      payload_valid_q <= payload_valid_d;
      packet_end_q    <= packet_end_d;
      aborted_q       <= aborted_d;
      crc_error_q     <= crc_error_d;
    end
  end

  assign phy_reset     = phy_reset_q;
  assign header_valid  = header_valid_q;
  assign data_id       = data_id_q;
  assign word_count    = word_count_q;
  assign ecc           = ecc_q;
  assign is_long       = is_long_q;
  assign payload       = payload_q;
  assign payload_valid = payload_valid_q;
  assign packet_end    = packet_end_q;
  assign aborted       = aborted_q;
  assign crc_error     = crc_error_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_rx_packet_controller.sv
`default_nettype none
// ==========================================================================
// tb_csi2_rx_packet_controller : scoreboard bench for the CSI-2 RX controller
// Rev 1.0
// ==========================================================================
module tb_csi2_rx_packet_controller;

  localparam int RESET_CYCLES = 4;
  localparam int TIMEOUT      = 64;
  localparam int K_HDR = 1;
  localparam int K_PAY = 2;
  localparam int K_END = 4;
`ifdef CSI2_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct { logic [7:0] di; logic [15:0] wc; logic [7:0] ecc; logic lng; int cyc; } hdr_t;
  typedef struct { logic [7:0] b; int cyc; } pay_t;
  typedef struct { logic err; int cyc; } end_t;

  logic        clock_p   = 1'b0;
  logic        reset_n   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_enable = 1'b0;
  logic        phy_reset, header_valid, is_long, payload_valid, packet_end, aborted, crc_error;
  logic [7:0]  data_id, ecc, payload;
  logic [15:0] word_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;
  int rst_run     = 0;
  int rst_seen    = 0;
  int seen0;

  hdr_t exp_hdr[$];
  pay_t exp_pay[$];
  end_t exp_end[$];
  int   exp_abt[$];
  hdr_t mh;
  pay_t mp;
  end_t me;
  int   ma;

  logic [7:0]  cur_di;
  logic [15:0] cur_wc;
  logic        cur_long;
  logic        cur_err;
  logic [7:0]  pl_q[$];

  csi2_rx_packet_controller #(
    .RESET_CYCLES (RESET_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock_p       (clock_p),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_enable     (rx_enable),
    .phy_reset     (phy_reset),
    .header_valid  (header_valid),
    .data_id       (data_id),
    .word_count    (word_count),
    .ecc           (ecc),
    .is_long       (is_long),
    .payload       (payload),
    .payload_valid (payload_valid),
    .packet_end    (packet_end),
    .aborted       (aborted),
    .crc_error     (crc_error)
  );

  always #5 clock_p = ~clock_p;
  always @(posedge clock_p) cyc <= cyc + 1;

  // Scoreboard: every output pulse pops and checks the oldest expectation.
  always @(negedge clock_p) begin
    if (!reset_n) begin
      rst_run = 0;
    end else begin
      if (header_valid) begin
        vectors++;
        if (exp_hdr.size() == 0) begin
          miscompares++;
          $display("FAIL header: unexpected pulse di=%02h at cycle %0d, required none", data_id, cyc);
        end else begin
          mh = exp_hdr.pop_front();
          if ({data_id, word_count, ecc, is_long} !== {mh.di, mh.wc, mh.ecc, mh.lng} || cyc != mh.cyc) begin
            miscompares++;
            $display("FAIL header: got di=%02h wc=%04h ecc=%02h long=%0b cyc=%0d, required di=%02h wc=%04h ecc=%02h long=%0b cyc=%0d",
                     data_id, word_count, ecc, is_long, cyc, mh.di, mh.wc, mh.ecc, mh.lng, mh.cyc);
          end
        end
      end
      if (payload_valid) begin
        vectors++;
        if (exp_pay.size() == 0) begin
          miscompares++;
          $display("FAIL payload: unexpected byte %02h at cycle %0d, required none", payload, cyc);
        end else begin
          mp = exp_pay.pop_front();
          if (payload !== mp.b || cyc != mp.cyc) begin
            miscompares++;
            $display("FAIL payload: got %02h cyc=%0d, required %02h cyc=%0d", payload, cyc, mp.b, mp.cyc);
          end
        end
      end
      if (packet_end) begin
        vectors++;
        if (exp_end.size() == 0) begin
          miscompares++;
          $display("FAIL packet_end: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          me = exp_end.pop_front();
          if (crc_error !== me.err || cyc != me.cyc) begin
            miscompares++;
            $display("FAIL packet_end: got crc_error=%0b cyc=%0d, required crc_error=%0b cyc=%0d",
                     crc_error, cyc, me.err, me.cyc);
          end
        end
      end
      if (aborted) begin
        vectors++;
        if (exp_abt.size() == 0) begin
          miscompares++;
          $display("FAIL aborted: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          ma = exp_abt.pop_front();
          if (cyc != ma) begin
            miscompares++;
            $display("FAIL aborted: got cyc=%0d, required cyc=%0d", cyc, ma);
          end
        end
      end
      if (phy_reset) begin
        rst_run++;
      end else if (rst_run != 0) begin
        vectors++;
        rst_seen++;
        if (rst_run != RESET_CYCLES) begin
          miscompares++;
          $display("FAIL phy_reset_len: got %0d clocks, required %0d", rst_run, RESET_CYCLES);
        end
        rst_run = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input int kind);
    @(negedge clock_p);
    rx_data   = b;
    rx_enable = 1'b1;
    last_cyc  = cyc;
    if ((kind & K_HDR) != 0) exp_hdr.push_back('{cur_di, cur_wc, b, cur_long, cyc + 1});
    if ((kind & K_PAY) != 0) exp_pay.push_back('{b, cyc + 1});
    if ((kind & K_END) != 0) exp_end.push_back('{cur_err, cyc + 1});
    @(negedge clock_p);
    rx_enable = 1'b0;
    repeat (gap - 2) @(negedge clock_p);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock_p);
    #1;
  endtask

  task automatic send_short(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] e);
    cur_di = di; cur_wc = wc; cur_long = 1'b0; cur_err = 1'b0;
    send_byte(di, 4, 0);
    send_byte(wc[7:0], 4, 0);
    send_byte(wc[15:8], 4, 0);
    send_byte(e, 8, K_HDR | K_END);
  endtask

  task automatic send_long(input logic [7:0] di, input bit flip, input int gap0);
    logic [15:0] crc;
    crc = 16'hFFFF;
    foreach (pl_q[i]) begin
      crc = crc ^ {8'h00, pl_q[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
    end
    if (flip) crc = crc ^ 16'h0100;
    cur_di = di; cur_wc = 16'(pl_q.size()); cur_long = 1'b1; cur_err = CRC_EN & flip;
    send_byte(di, 4, 0);
    send_byte(cur_wc[7:0], 4, 0);
    send_byte(cur_wc[15:8], 4, 0);
    send_byte(8'h3C, 4, K_HDR);
    foreach (pl_q[i]) send_byte(pl_q[i], (i == 0) ? gap0 : 4, K_PAY);
    send_byte(crc[7:0], 4, 0);
    send_byte(crc[15:8], 8, K_END);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    settle(3);
    vectors++;
    if ({phy_reset, header_valid, payload_valid, packet_end, aborted, crc_error} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %06b, required 100000",
               {phy_reset, header_valid, payload_valid, packet_end, aborted, crc_error});
    end
    vectors++;
    if ({data_id, word_count, ecc, is_long, payload} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_fields: got di=%02h wc=%04h ecc=%02h long=%0b pl=%02h, required all 0",
               data_id, word_count, ecc, is_long, payload);
    end
    @(posedge clock_p);
    #1 reset_n = 1'b1;
    seen0 = rst_seen;
    settle(4);
    vectors++;
    if (phy_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: got phy_reset=%0b in 4th clock, required 1", phy_reset);
    end
    settle(1);
    vectors++;
    if (phy_reset !== 1'b0 || rst_seen != seen0 + 1) begin
      miscompares++;
      $display("FAIL reset_release: got phy_reset=%0b runs=%0d, required 0 and %0d", phy_reset, rst_seen - seen0, 1);
    end
  endtask

  task automatic test_short_packet();
    seen0 = rst_seen;
    send_short(8'h00, 16'h0001, 8'h5A);
    send_short(8'h0F, 16'hBEEF, 8'hC3);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size() != 0 || rst_seen != seen0 + 2) begin
      miscompares++;
      $display("FAIL short_drain: got %0d outstanding, %0d resets, required 0 and 2",
               exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size(), rst_seen - seen0);
    end
    vectors++;
    if ({data_id, word_count, ecc, is_long} !== {8'h0F, 16'hBEEF, 8'hC3, 1'b0}) begin
      miscompares++;
      $display("FAIL short_hold: got di=%02h wc=%04h ecc=%02h long=%0b, required 0f beef c3 0",
               data_id, word_count, ecc, is_long);
    end
  endtask

  task automatic test_long_packet();
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_long(8'h2A, 1'b0, 4);
    pl_q = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
    send_long(8'h92, 1'b1, 4);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size() != 0 || payload !== 8'hFF) begin
      miscompares++;
      $display("FAIL long_drain: got %0d outstanding, payload=%02h, required 0 and ff",
               exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size(), payload);
    end
  endtask

  task automatic test_wc_zero();
    pl_q.delete();
    send_long(8'h10, 1'b0, 4);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_end.size() != 0 || word_count !== 16'h0000 || is_long !== 1'b1) begin
      miscompares++;
      $display("FAIL wc_zero: got %0d outstanding wc=%04h long=%0b, required 0 0000 1",
               exp_hdr.size() + exp_end.size(), word_count, is_long);
    end
  endtask

  task automatic test_timeout();
    seen0 = rst_seen;
    cur_di = 8'h2A; cur_wc = 16'd5; cur_long = 1'b1; cur_err = 1'b0;
    send_byte(8'h2A, 4, 0);
    send_byte(8'h05, 4, 0);
    send_byte(8'h00, 4, 0);
    send_byte(8'h7E, 4, K_HDR);
    send_byte(8'hA1, 4, K_PAY);
    send_byte(8'hA2, 4, K_PAY);
    exp_abt.push_back(last_cyc + 1 + TIMEOUT);
    settle(TIMEOUT + 16);
    vectors++;
    if (exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size() != 0 || rst_seen != seen0 + 1) begin
      miscompares++;
      $display("FAIL timeout_drain: got %0d outstanding, %0d resets, required 0 and 1",
               exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size(), rst_seen - seen0);
    end
    send_short(8'h01, 16'h1234, 8'h77);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_end.size() != 0 || data_id !== 8'h01) begin
      miscompares++;
      $display("FAIL after_timeout: got %0d outstanding di=%02h, required 0 and 01",
               exp_hdr.size() + exp_end.size(), data_id);
    end
  endtask

  task automatic test_timeout_boundary();
    pl_q = '{8'hC0, 8'hDE};
    send_long(8'h6A, 1'b0, TIMEOUT);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_edge: got %0d outstanding, required 0",
               exp_hdr.size() + exp_pay.size() + exp_end.size() + exp_abt.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    cur_di = 8'h2A; cur_wc = 16'd8; cur_long = 1'b1; cur_err = 1'b0;
    send_byte(8'h2A, 4, 0);
    send_byte(8'h08, 4, 0);
    send_byte(8'h00, 4, 0);
    send_byte(8'h19, 4, K_HDR);
    send_byte(8'hB1, 4, K_PAY);
    send_byte(8'hB2, 2, K_PAY);
    @(negedge clock_p);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({phy_reset, header_valid, payload_valid, packet_end, aborted, crc_error} !== 6'b100000 ||
        {data_id, word_count, ecc} !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got flags=%06b di=%02h wc=%04h ecc=%02h, required 100000 and zeros",
               {phy_reset, header_valid, payload_valid, packet_end, aborted, crc_error}, data_id, word_count, ecc);
    end
    exp_hdr.delete(); exp_pay.delete(); exp_end.delete(); exp_abt.delete();
    settle(2);
    @(posedge clock_p);
    #1 reset_n = 1'b1;
    seen0 = rst_seen;
    settle(8);
    send_short(8'h00, 16'h0002, 8'h11);
    settle(4);
    vectors++;
    if (exp_hdr.size() + exp_end.size() != 0 || word_count !== 16'h0002 || rst_seen != seen0 + 2) begin
      miscompares++;
      $display("FAIL after_mid_reset: got %0d outstanding wc=%04h resets=%0d, required 0 0002 2",
               exp_hdr.size() + exp_end.size(), word_count, rst_seen - seen0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_short_packet();
    test_long_packet();
    test_wc_zero();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
